// File: rtl/latency_mem.sv
// rtl/latency_mem.sv - fixed-latency single-port word memory with byte enables
// One request in flight; responses are held until the consumer takes them.
module latency_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [31:0]         access_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  if (DATA_W < 8 || DATA_W % 8 != 0 || LATENCY < 1) begin : g_bad_param
    $fatal(1, "latency_mem: illegal DATA_W or LATENCY");
  end

  // Address bits above the word index alias onto the same word.
  if (ADDR_W + 2 < 32) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^req_addr[31:ADDR_W+2];
  end

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] merged;
  logic              access_fire;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign access_fire = (state == ACCESS) && (cnt == '0);
  assign mem_word    = mem[idx_q];

  always_comb begin
    merged = mem_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      access_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            err_q   <= (req_addr[1:0] != 2'b00);
            idx_q   <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state    <= RESP;
            resp_err <= err_q;
            if (err_q) begin
              resp_rdata <= '0;
            end else begin
              resp_rdata   <= wr_q ? merged : mem_word;
              access_count <= access_count + 32'd1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; an aborted access never reaches here.
  always_ff @(posedge clk) begin
    if (access_fire && wr_q && !err_q) mem[idx_q] <= merged;
  end

endmodule

// File: tb/tb_latency_mem.sv
// tb/tb_latency_mem.sv - self-checking bench for latency_mem
// Cycle model of the request/response contract plus directed literal checks.
module tb_latency_mem;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] access_count;

  int n_checks = 0;
  int n_err    = 0;
  bit run_chk  = 1'b0;

  latency_mem #(.DATA_W(32), .ADDR_W(16), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: memory as a sparse word array, one transaction in flight.
  logic [31:0] mm [int];
  int          cycle = 0;
  bit          m_busy;
  int          m_acc;
  bit          m_write;
  bit          m_err;
  int          m_idx;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] exp_rdata;
  bit          exp_err;
  logic [31:0] exp_count;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy    = 1'b0;
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      exp_count = 32'h0;
    end else begin
      cycle++;
      if (m_busy && cycle > m_acc + LAT && resp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && req_valid) begin
        m_busy  = 1'b1;
        m_acc   = cycle;
        m_write = req_write;
        m_err   = (req_addr % 4) != 0;
        m_idx   = int'((req_addr / 4) % 65536);
        m_wdata = req_wdata;
        m_be    = req_be;
      end
      if (m_busy && cycle == m_acc + LAT) begin
        logic [31:0] old;
        old     = mm.exists(m_idx) ? mm[m_idx] : 32'hxxxxxxxx;
        exp_err = m_err;
        if (m_err) begin
          exp_rdata = 32'h0;
        end else begin
          exp_count = exp_count + 32'd1;
          if (m_write) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) old[8*b +: 8] = m_wdata[8*b +: 8];
            mm[m_idx] = old;
          end
          exp_rdata = old;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && run_chk) begin
      if (!m_busy) begin
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
      end else if (cycle < m_acc + LAT) begin
        chk("access_req_ready", {31'd0, req_ready}, 32'd0);
        chk("access_resp_valid", {31'd0, resp_valid}, 32'd0);
      end else begin
        chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      end
      chk("access_count", access_count, exp_count);
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_be     = be;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (lat == 0) begin
        // Garbage on the request bus while busy must be ignored.
        req_write = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0;
        req_be    = 4'hF;
      end
      if (resp_valid) break;
      lat++;
      if (lat > 50) begin
        chk("resp_timeout", 32'd0, 32'd1);
        break;
      end
    end
    req_valid = 1'b0;
    rd  = resp_rdata;
    err = resp_err;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    resp_ready = 1'b1;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_count", access_count, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_chk = 1'b1;

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err, lat);
    chk("w_full_rdata", rd, 32'hDEADBEEF);
    chk("w_full_err", {31'd0, err}, 32'd0);
    chk("w_full_latency", lat, LAT);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat);
    chk("r_full_rdata", rd, 32'hDEADBEEF);
    chk("count_after_two", access_count, 32'd2);

    do_req(1'b1, 32'h10, 32'h11223344, 4'h5, 0, rd, err, lat);
    chk("w_be5_rdata", rd, 32'hDE22BE44);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat);
    chk("r_be5_rdata", rd, 32'hDE22BE44);

    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, err, lat);
    chk("w_be0_rdata", rd, 32'hDE22BE44);

    do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, err, lat);
    chk("mis_rd_err", {31'd0, err}, 32'd1);
    chk("mis_rd_rdata", rd, 32'h0);
    chk("mis_rd_count", access_count, 32'd5);
    do_req(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, rd, err, lat);
    chk("mis_wr_err", {31'd0, err}, 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat);
    chk("after_mis_rdata", rd, 32'hDE22BE44);
    chk("after_mis_count", access_count, 32'd6);

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, err, lat);
    chk("hold_read_rdata", rd, 32'hDE22BE44);

    do_req(1'b1, 32'h0004_0010, 32'h5A5A1234, 4'hF, 0, rd, err, lat);
    chk("alias_w_err", {31'd0, err}, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat);
    chk("alias_r_rdata", rd, 32'h5A5A1234);
    chk("alias_r_err", {31'd0, err}, 32'd0);

    do_req(1'b1, 32'h20, 32'h0BADCAFE, 4'hF, 0, rd, err, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_err", {31'd0, resp_err}, 32'd0);
    chk("abort_count", access_count, 32'h0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat);
    chk("abort_read_rdata", rd, 32'h0BADCAFE);
    chk("abort_read_count", access_count, 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/latency_mem.md
LATENCY_MEM -- requirements
Module: latency_mem

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, word-index width; depth SHALL be 2^ADDR_W words.
REQ-003 Parameter LATENCY, default 3, access latency in cycles; SHALL be >= 1.
REQ-004 Parameter DATA_W < 8, DATA_W % 8 != 0 or LATENCY < 1 SHALL stop elaboration with a fatal error.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  response consumer ready.
REQ-015 resp_rdata  output  DATA_W  read data, or merged word after a write.
REQ-016 resp_err  output  1  request was misaligned.
REQ-017 access_count  output  32  number of completed, error-free accesses.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept = req_valid && req_ready at a rising edge; SHALL latch write, word index, wdata, be; load latency counter with LATENCY-1; go to ACCESS.
REQ-020 ACCESS: counter decrements every cycle; on the edge where counter == 0, the access SHALL be performed and state SHALL go to RESP.
REQ-021 Accept at edge k SHALL give resp_valid = 1 after edge k+LATENCY, never earlier.
REQ-022 Read: resp_rdata SHALL be registered with the addressed word at access time.
REQ-023 Write: only byte lanes with be = 1 SHALL be updated; resp_rdata SHALL be the merged new word; be = 0 SHALL leave memory unchanged and still respond.
REQ-024 req_addr[1:0] != 0: no memory write, resp_rdata = 0, resp_err = 1, access_count not incremented; otherwise resp_err = 0.
REQ-025 req_addr bits above ADDR_W+1 SHALL be ignored (address aliasing), no error.
REQ-026 RESP: resp_valid, resp_rdata, resp_err SHALL hold stable until resp_valid && resp_ready; on that edge state SHALL go to IDLE and resp_valid SHALL drop.
REQ-027 Minimum request period SHALL be LATENCY+2 cycles with resp_ready held at 1.
REQ-028 req_* inputs SHALL be ignored outside IDLE; request inputs changing after accept SHALL not affect the access in flight.
REQ-029 access_count SHALL increment by 1 on each error-free access edge (REQ-020), wrapping 0xFFFFFFFF -> 0.
REQ-030 Memory contents SHALL NOT be initialised or cleared by reset; reads of never-written words return X in simulation.

Reset
REQ-031 reset_n = 0 SHALL immediately force IDLE, req_ready = 1 once reset_n = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, access_count = 0, latency counter = 0.
REQ-032 Reset during ACCESS before the access edge SHALL abort the pending write with no memory change; a write already performed SHALL persist.
REQ-033 reset_n release SHALL not cause an accept before the first rising edge with reset_n = 1.

Verification (LATENCY = 3, DATA_W = 32, ADDR_W = 16)
REQ-034 Write 0xDEADBEEF to 0x00000010 with be = 0xF, accepted edge k -> resp_valid after edge k+3, resp_rdata = 0xDEADBEEF, resp_err = 0; read of 0x10 returns 0xDEADBEEF; access_count = 2.
REQ-035 Word 0x10 = 0xDEADBEEF, write 0x11223344 with be = 0x5 -> resp_rdata = 0xDE22BE44; subsequent read returns 0xDE22BE44.
REQ-036 Read of 0x00000012 -> resp_err = 1, resp_rdata = 0, access_count unchanged; write to 0x00000013 leaves memory unchanged.
REQ-037 resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_rdata stable, req_ready = 0 throughout; IDLE one edge after resp_ready = 1.
REQ-038 Write 0xCAFEF00D to 0x20 accepted, reset_n pulsed low one cycle later -> all outputs at reset values immediately; later read of 0x20 returns prior contents, not 0xCAFEF00D.
REQ-039 Write to 0x00040010 then read 0x00000010 -> same data (aliasing), resp_err = 0 both times.
